// File: rtl/cpu_step_controller.sv
// Run/step/breakpoint sequencer that gates the single-cycle CPU datapath.
// Conditions the raw step button and counts executed (enabled) cycles.
module cpu_step_controller #(
  parameter int unsigned NBITS_TOP       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 run_sw,
  input  logic                 step_btn,
  input  logic                 bp_en,
  input  logic [NBITS_TOP-1:0] bp_addr,
  input  logic [NBITS_TOP-1:0] pc,
  input  logic                 halt_req,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic                 bp_hit,
  output logic [NBITS_TOP-1:0] step_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  state_e               state_q;
  logic                 first_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic [DW-1:0]        deb_q;
  logic [NBITS_TOP-1:0] count_q;
  logic                 step_pulse;
  logic                 bp_match;

  // Strobe on the cycle the debounce counter steps onto its saturation value.
  assign step_pulse = sync2_q && (deb_q == (DEB_MAX - DW'(1)));
  assign bp_match   = bp_en && (pc == bp_addr) && !first_q;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
    end else begin
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
      if (!sync2_q) begin
        deb_q <= '0;
      end else if (deb_q != DEB_MAX) begin
        deb_q <= deb_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= ST_HALT;
      first_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        ST_HALT: begin
          if (run_sw) begin
            state_q <= ST_RUN;
            first_q <= 1'b1;
          end else if (step_pulse) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (!run_sw || halt_req) begin
            state_q <= ST_HALT;
          end else if (bp_match) begin
            state_q <= ST_BREAK;
          end
        end
        ST_STEP: state_q <= ST_HALT;
        ST_BREAK: begin
          if (!run_sw) begin
            state_q <= ST_HALT;
          end else if (step_pulse) begin
            state_q <= ST_STEP;
          end
        end
      endcase
    end
  end

  // Enable must react to pc/halt_req in the same cycle, so it is decoded, not registered.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:  cpu_en = run_sw && !halt_req && !bp_match;
      ST_STEP: cpu_en = !halt_req;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (cpu_en) begin
      count_q <= count_q + NBITS_TOP'(1);
    end
  end

  assign state      = state_q;
  assign bp_hit     = (state_q == ST_BREAK);
  assign step_count = count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller: behavioural model compared every cycle
// plus literal expectations taken from the stepping scenarios.
`timescale 1ns/100ps
module tb_cpu_step_controller;

  localparam int D = 4;
  localparam int S_HALT = 0, S_RUN = 1, S_STEP = 2, S_BREAK = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_sw = 1'b0;
  logic       step_btn = 1'b0;
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = 8'h00;
  logic [7:0] pc = 8'h00;
  logic       halt_req = 1'b0;
  logic       cpu_en;
  logic [1:0] state;
  logic       bp_hit;
  logic [7:0] step_count;

  logic       pc_load = 1'b0;
  logic [7:0] pc_load_val = 8'h00;

  int checks = 0;
  int failures = 0;

  // Model state: architectural state, executed count, first flag, button history.
  int   m_state = S_HALT;
  int   m_count = 0;
  bit   m_first = 1'b0;
  int   run_len = 0;
  bit   btn_seen1 = 1'b0;
  bit   btn_seen2 = 1'b0;

  cpu_step_controller #(.NBITS_TOP(8), .DEBOUNCE_CYCLES(D)) dut (
    .clk_2(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .halt_req(halt_req),
    .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .step_count(step_count)
  );

  always #5 clk = ~clk;

  function automatic bit m_en();
    bit bpm;
    bpm = bp_en && (pc == bp_addr) && !m_first;
    if (m_state == S_RUN)  return run_sw && !halt_req && !bpm;
    if (m_state == S_STEP) return !halt_req;
    return 1'b0;
  endfunction

  // A press is accepted once the button has been seen high (two edges late) D cycles running.
  function automatic bit m_pulse();
    return btn_seen2 && (run_len == D - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    bit en, pulse, bpm;
    if (reset) begin
      m_state = S_HALT; m_count = 0; m_first = 1'b0;
      run_len = 0; btn_seen1 = 1'b0; btn_seen2 = 1'b0;
      pc <= 8'h00;
    end else begin
      en    = m_en();
      pulse = m_pulse();
      bpm   = bp_en && (pc == bp_addr) && !m_first;
      pc <= pc_load ? pc_load_val : (en ? pc + 8'd1 : pc);
      if (en) m_count = (m_count + 1) % 256;
      m_first = (m_state == S_HALT) && run_sw;
      case (m_state)
        S_HALT:  m_state = run_sw ? S_RUN : (pulse ? S_STEP : S_HALT);
        S_RUN:   m_state = (!run_sw || halt_req) ? S_HALT : (bpm ? S_BREAK : S_RUN);
        S_STEP:  m_state = S_HALT;
        default: m_state = !run_sw ? S_HALT : (pulse ? S_STEP : S_BREAK);
      endcase
      run_len   = btn_seen2 ? run_len + 1 : 0;
      btn_seen2 = btn_seen1;
      btn_seen1 = step_btn;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("cpu_en", int'(cpu_en), int'(m_en()));
    chk("state", int'(state), m_state);
    chk("bp_hit", int'(bp_hit), int'(m_state == S_BREAK));
    chk("step_count", int'(step_count), m_count);
  endtask

  // Each tick compares the outputs mid-cycle, then lands just after the next rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit pat [14];
    pat = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    reset = 1'b1;
    tick(2);
    chk("reset_state", int'(state), 0);
    chk("reset_cpu_en", int'(cpu_en), 0);
    reset = 1'b0;
    pc_load = 1'b1; pc_load_val = 8'h00;
    tick(1);
    pc_load = 1'b0;

    // Free run and wrap
    run_sw = 1'b1;
    tick(1);
    chk("run_entry_state", int'(state), S_RUN);
    chk("run_entry_en", int'(cpu_en), 1);
    tick(10);
    chk("run10_count", int'(step_count), 10);
    chk("run10_pc", int'(pc), 10);
    tick(245);
    chk("count_255", int'(step_count), 255);
    tick(1);
    chk("count_wrap", int'(step_count), 0);
    run_sw = 1'b0;
    tick(1);
    chk("run_off_halt", int'(state), S_HALT);

    // Breakpoint at 5
    pc_load = 1'b1; pc_load_val = 8'h00; bp_en = 1'b1; bp_addr = 8'h05;
    tick(1);
    pc_load = 1'b0; run_sw = 1'b1;
    tick(6);
    chk("bp_pc5", int'(pc), 5);
    chk("bp_en_drop", int'(cpu_en), 0);
    tick(1);
    chk("bp_state", int'(state), S_BREAK);
    chk("bp_hit", int'(bp_hit), 1);
    chk("bp_count", int'(step_count), 5);
    tick(3);
    chk("bp_pc_hold", int'(pc), 5);

    // Resume past the breakpoint
    run_sw = 1'b0;
    tick(1);
    chk("resume_halt", int'(state), S_HALT);
    run_sw = 1'b1;
    tick(1);
    chk("resume_first_en", int'(cpu_en), 1);
    tick(1);
    chk("resume_pc6", int'(pc), 6);
    tick(3);
    chk("resume_pc9", int'(pc), 9);
    run_sw = 1'b0;
    tick(1);

    // Single step from HALT, then bounce
    bp_en = 1'b0; step_btn = 1'b1;
    tick(5);
    chk("step_wait", int'(state), S_HALT);
    tick(1);
    chk("step_state", int'(state), S_STEP);
    chk("step_en", int'(cpu_en), 1);
    tick(1);
    chk("step_done", int'(state), S_HALT);
    chk("step_count", int'(step_count), 10);
    chk("step_pc", int'(pc), 10);
    tick(3);
    step_btn = 1'b0;
    tick(4);
    foreach (pat[i]) begin
      step_btn = pat[i];
      tick(1);
    end
    chk("bounce_state", int'(state), S_HALT);
    chk("bounce_count", int'(step_count), 10);

    // halt_req in RUN
    pc_load = 1'b1; pc_load_val = 8'h00;
    tick(1);
    pc_load = 1'b0; run_sw = 1'b1;
    tick(4);
    chk("halt_pc3", int'(pc), 3);
    halt_req = 1'b1;
    #1;
    chk("halt_en_same", int'(cpu_en), 0);
    tick(1);
    chk("halt_state", int'(state), S_HALT);
    chk("halt_count", int'(step_count), 13);
    halt_req = 1'b0; run_sw = 1'b0;
    tick(2);

    // run_sw and step_pulse together in HALT
    step_btn = 1'b1;
    tick(5);
    run_sw = 1'b1;
    tick(1);
    chk("race_run_wins", int'(state), S_RUN);
    tick(3);
    chk("race_still_run", int'(state), S_RUN);
    step_btn = 1'b0;
    tick(4);

    // Asynchronous reset mid-RUN with a press in progress
    step_btn = 1'b1;
    tick(3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_en", int'(cpu_en), 0);
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_count", int'(step_count), 0);
    step_btn = 1'b0; run_sw = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(10);
    chk("post_rst_no_step", int'(state), S_HALT);
    chk("post_rst_count", int'(step_count), 0);
    step_btn = 1'b1;
    tick(6);
    chk("new_press_step", int'(state), S_STEP);
    tick(1);
    chk("new_press_count", int'(step_count), 1);
    step_btn = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Run/step/breakpoint sequencer for the single-cycle CPU datapath on the board.
- Produces the datapath clock-enable `cpu_en` from board switches, a debounced step button, a PC breakpoint comparator and a CPU halt request.
- Exposes state and an executed-instruction counter for the LED/LCD debug display.
- Sits between SWI/button inputs and the CPU core; all CPU state registers advance only when `cpu_en=1`.

Parameters:
NBITS_TOP, 8, width of PC, breakpoint address and step counter
DEBOUNCE_CYCLES, 4, consecutive synchronized-high cycles required to accept a step press (>=1)

Ports:
clk_2  input  1  system clock; all flops on posedge
reset  input  1  asynchronous, active-high reset
run_sw  input  1  run switch; level, already synchronous to clk_2
step_btn  input  1  raw step push-button; asynchronous, bouncy
bp_en  input  1  breakpoint enable
bp_addr  input  NBITS_TOP  breakpoint PC
pc  input  NBITS_TOP  current CPU PC
halt_req  input  1  CPU requests stop (e.g. ecall/illegal instruction); level
cpu_en  output  1  datapath clock-enable
state  output  2  0=HALT, 1=RUN, 2=STEP, 3=BREAK
bp_hit  output  1  high while in BREAK
step_count  output  NBITS_TOP  number of cycles with cpu_en=1, modulo 2^NBITS_TOP

Behaviour:
Reset:
- Asynchronous, active-high; applies mid-operation too.
- Forces state=HALT, step_count=0, debounce counter=0, synchronizer flops=0, first-cycle flag=0.
- Any pending step press is dropped.
- Outputs during and after reset: cpu_en=0, bp_hit=0.

Step input conditioning:
- step_btn passes through a 2-flop synchronizer giving `s`.
- Debounce counter increments while s=1, saturating at DEBOUNCE_CYCLES; clears to 0 when s=0.
- step_pulse is a one-cycle internal strobe in the cycle the counter transitions to DEBOUNCE_CYCLES.
- One press yields exactly one pulse. A new pulse requires s=0 for at least 1 cycle first.
- Latency from the step_btn rising edge to step_pulse: 2 + DEBOUNCE_CYCLES cycles.

Definitions:
- first: a 1-cycle flag, set on the HALT->RUN transition, cleared after the first RUN cycle.
- bp_match = bp_en & (pc == bp_addr) & ~first.

cpu_en (combinational from registered state and current inputs):
- RUN: cpu_en = run_sw & ~halt_req & ~bp_match.
- STEP: cpu_en = ~halt_req.
- HALT, BREAK: cpu_en = 0.

Transitions, evaluated in priority order within each state:
- HALT: run_sw=1 -> RUN (set first); else step_pulse -> STEP; else stay. If run_sw=1 and step_pulse occur in the same cycle, RUN wins and the pulse is discarded.
- RUN:
  - run_sw=0 -> HALT.
  - else halt_req -> HALT.
  - else bp_match -> BREAK.
  - else stay.
  - The instruction at bp_addr is not executed on entering BREAK.
- STEP: always -> HALT after exactly one cycle. Exactly one instruction executes unless halt_req is high. step_pulse arriving in STEP is ignored.
- BREAK:
  - run_sw=0 -> HALT.
  - else step_pulse -> STEP; this executes the breakpoint instruction.
  - else stay.
  - To resume free-running, lower run_sw (-> HALT), then raise it. The `first` flag masks the breakpoint for one cycle, so execution continues past bp_addr.

step_count:
- Increments on every posedge where cpu_en=1.
- Wraps from 2^NBITS_TOP-1 to 0, with no flag.
- Is not cleared by leaving RUN.

bp_hit = (state==BREAK), registered-state decode with no extra latency.

Width rule: the pc/bp_addr compare is full NBITS_TOP-bit unsigned equality.

Test Plan:
- Reset, then run_sw=1 with pc incrementing 0,1,2… from a bench model gated by cpu_en, bp_en=0 -> state=RUN one cycle after run_sw rises; cpu_en=1 continuously; step_count=10 after 10 enabled cycles; wrap check: 255 -> 0.
- bp_en=1, bp_addr=8'h05, run from pc=0 -> cpu_en drops in the cycle pc=5; state=BREAK, bp_hit=1; step_count=5; pc holds at 5.
- From BREAK, lower run_sw for 1 cycle then raise it -> HALT, then RUN. The first RUN cycle has cpu_en=1 despite pc=5; pc reaches 6 and runs on.
- From HALT, hold step_btn high for 10 cycles with DEBOUNCE_CYCLES=4 -> exactly one STEP cycle, at cycle 6 after the press. cpu_en=1 for exactly 1 cycle; step_count +1. Bounce pattern 1,0,1,0 with high runs <4 cycles -> no step.
- In RUN, assert halt_req at pc=3 -> cpu_en=0 in that same cycle; state=HALT next cycle. In HALT, assert run_sw and step_pulse in the same cycle -> RUN taken; no STEP occurs.
- Assert reset asynchronously mid-RUN, between clock edges -> cpu_en=0, state=0, step_count=0 immediately. A step press in progress is lost; no step occurs after reset deasserts until a new press.
